// File: rtl/bram_debug_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bram_debug_sequencer                                          |
// | Purpose  : Load / reset / run / dump sequencer for the RV32I core's      |
// |            block-RAM debug ports. Streams host words into NUM_MEM        |
// |            memories, holds then releases the core reset, runs the core   |
// |            for a bounded time or until halt, then streams every memory   |
// |            back out with address and memory tags.                        |
// | Ports    : CPU_CLK/CPU_RST      clock, synchronous active-high reset     |
// |            i_start, i_halt      sequence start, early end of RUN         |
// |            i_in_*/o_in_ready    load stream (valid/ready, last per mem)  |
// |            o_out_*/i_out_ready  dump stream (data, byte addr, mem, last) |
// |            o_dbg_a/wd/we, i_dbg_rd  per-memory debug ports               |
// |            o_core_rst, o_busy, o_done  core reset and status             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bram_debug_sequencer #(
  parameter int WORDS      = 4096,
  parameter int NUM_MEM    = 2,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000,
  parameter int RD_LATENCY = 2
) (
  input  logic                       CPU_CLK,
  input  logic                       CPU_RST,
  input  logic                       i_start,
  input  logic                       i_halt,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_in_data,
  input  logic                       i_in_last,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [31:0]                o_out_data,
  output logic [31:0]                o_out_addr,
  output logic [$clog2(NUM_MEM)-1:0] o_out_mem,
  output logic                       o_out_last,
  output logic [32*NUM_MEM-1:0]      o_dbg_a,
  output logic [31:0]                o_dbg_wd,
  output logic [4*NUM_MEM-1:0]       o_dbg_we,
  input  logic [32*NUM_MEM-1:0]      i_dbg_rd,
  output logic                       o_core_rst,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int c_MW = $clog2(NUM_MEM);
  localparam int c_WW = $clog2(WORDS);
  localparam logic [c_MW-1:0] c_M_LAST    = c_MW'(NUM_MEM - 1);
  localparam logic [c_WW-1:0] c_W_LAST    = c_WW'(WORDS - 1);
  localparam logic [31:0]     c_HOLD_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]     c_RUN_LAST  = 32'(RUN_CYCLES - 1);
  localparam logic [31:0]     c_WAIT_LAST = 32'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_HOLD      = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_ADDR = 3'd4,
    S_DUMP_WAIT = 3'd5,
    S_DUMP_OUT  = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_MW-1:0]       r_m, w_m_nxt;
  logic [c_WW-1:0]       r_w, w_w_nxt;
  logic [31:0]           r_cnt, w_cnt_nxt;
  logic [32*NUM_MEM-1:0] r_dbg_a, w_dbg_a_nxt;
  logic [31:0]           r_dbg_wd, w_dbg_wd_nxt;
  logic [4*NUM_MEM-1:0]  r_dbg_we, w_dbg_we_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [31:0]           r_out_data, w_out_data_nxt;
  logic [31:0]           r_out_addr, w_out_addr_nxt;
  logic [c_MW-1:0]       r_out_mem, w_out_mem_nxt;
  logic                  r_out_last, w_out_last_nxt;
  logic [31:0]           w_rd_sel;

  function automatic logic [31:0] f_baddr(input logic [c_WW-1:0] w);
    return 32'({w, 2'b00});
  endfunction

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_w         <= '0;
      r_cnt       <= '0;
      r_dbg_a     <= '0;
      r_dbg_wd    <= '0;
      r_dbg_we    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_mem   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_m         <= w_m_nxt;
      r_w         <= w_w_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dbg_a     <= w_dbg_a_nxt;
      r_dbg_wd    <= w_dbg_wd_nxt;
      r_dbg_we    <= w_dbg_we_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_mem   <= w_out_mem_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_m_nxt         = r_m;
    w_w_nxt         = r_w;
    w_cnt_nxt       = r_cnt;
    // Address and write enables fall back to zero every cycle, so a write
    // pulse lasts exactly one cycle and idle slices read as zero.
    w_dbg_a_nxt     = '0;
    w_dbg_wd_nxt    = r_dbg_wd;
    w_dbg_we_nxt    = '0;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_mem_nxt   = r_out_mem;
    w_out_last_nxt  = r_out_last;

    w_rd_sel = '0;
    for (int k = 0; k < NUM_MEM; k++) begin
      if (r_m == c_MW'(k)) w_rd_sel = i_dbg_rd[k*32 +: 32];
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
          w_m_nxt     = '0;
          w_w_nxt     = '0;
        end
      end

      S_LOAD: begin
        if (i_in_valid) begin
          for (int k = 0; k < NUM_MEM; k++) begin
            if (r_m == c_MW'(k)) begin
              w_dbg_a_nxt[k*32 +: 32] = f_baddr(r_w);
              w_dbg_we_nxt[k*4 +: 4]  = 4'hF;
            end
          end
          w_dbg_wd_nxt = i_in_data;
          if ((r_w == c_W_LAST) || i_in_last) begin
            w_w_nxt = '0;
            if (r_m == c_M_LAST) begin
              w_m_nxt     = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_HOLD;
            end else begin
              w_m_nxt = r_m + c_MW'(1);
            end
          end else begin
            w_w_nxt = r_w + c_WW'(1);
          end
        end
      end

      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_RUN: begin
        if ((r_cnt == c_RUN_LAST) || i_halt) begin
          w_m_nxt     = '0;
          w_w_nxt     = '0;
          w_state_nxt = S_DUMP_ADDR;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_DUMP_ADDR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DUMP_WAIT;
      end

      S_DUMP_WAIT: begin
        if (r_cnt == c_WAIT_LAST) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_rd_sel;
          w_out_addr_nxt  = f_baddr(r_w);
          w_out_mem_nxt   = r_m;
          w_out_last_nxt  = (r_m == c_M_LAST) && (r_w == c_W_LAST);
          w_state_nxt     = S_DUMP_OUT;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_DUMP_OUT: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          if (r_w == c_W_LAST) begin
            w_w_nxt = '0;
            if (r_m == c_M_LAST) begin
              w_m_nxt     = '0;
              w_state_nxt = S_DONE;
            end else begin
              w_m_nxt     = r_m + c_MW'(1);
              w_state_nxt = S_DUMP_ADDR;
            end
          end else begin
            w_w_nxt     = r_w + c_WW'(1);
            w_state_nxt = S_DUMP_ADDR;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Dump address is a function of the word about to be read: it appears
    // on the first DUMP_ADDR cycle and stays put until that word is accepted.
    if ((w_state_nxt == S_DUMP_ADDR) || (w_state_nxt == S_DUMP_WAIT) ||
        (w_state_nxt == S_DUMP_OUT)) begin
      for (int k = 0; k < NUM_MEM; k++) begin
        if (w_m_nxt == c_MW'(k)) w_dbg_a_nxt[k*32 +: 32] = f_baddr(w_w_nxt);
      end
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_core_rst  = (r_state != S_RUN);
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_mem   = r_out_mem;
  assign o_out_last  = r_out_last;
  assign o_dbg_a     = r_dbg_a;
  assign o_dbg_wd    = r_dbg_wd;
  assign o_dbg_we    = r_dbg_we;

endmodule
`default_nettype wire

// File: tb/tb_bram_debug_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bram_debug_sequencer                                       |
// | Purpose  : Self-checking bench for bram_debug_sequencer with behavioural |
// |            block-RAM models on the debug ports and an expected-contents  |
// |            array driven from the load stimulus.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bram_debug_sequencer;

  localparam int WORDS      = 8;
  localparam int NUM_MEM    = 2;
  localparam int RST_CYCLES = 5;
  localparam int RUN_CYCLES = 20;
  localparam int RD_LATENCY = 2;
  localparam int TOTAL      = WORDS * NUM_MEM;
  localparam int c_AW       = $clog2(WORDS);
  localparam int c_MW       = $clog2(NUM_MEM);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start, halt, in_valid, in_last, out_ready;
  logic [31:0]           in_data;
  logic                  in_ready, out_valid, out_last, core_rst, busy, done;
  logic [31:0]           out_data, out_addr, dbg_wd;
  logic [c_MW-1:0]       out_mem;
  logic [32*NUM_MEM-1:0] dbg_a, dbg_rd;
  logic [4*NUM_MEM-1:0]  dbg_we;

  always #5 clk = ~clk;

  bram_debug_sequencer #(
    .WORDS(WORDS), .NUM_MEM(NUM_MEM), .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_CYCLES), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .CPU_CLK(clk), .CPU_RST(rst), .i_start(start), .i_halt(halt),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .i_in_last(in_last), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_addr(out_addr), .o_out_mem(out_mem),
    .o_out_last(out_last), .o_dbg_a(dbg_a), .o_dbg_wd(dbg_wd),
    .o_dbg_we(dbg_we), .i_dbg_rd(dbg_rd), .o_core_rst(core_rst),
    .o_busy(busy), .o_done(done)
  );

  // Block-RAM models: byte-enabled write, RD_LATENCY-stage read pipeline.
  logic [31:0] bram  [NUM_MEM][WORDS];
  logic [31:0] rpipe [NUM_MEM][RD_LATENCY];
  logic        tb_init;
  int unsigned we_cnt [NUM_MEM];

  function automatic logic [31:0] pat(input int m, input int w);
    return 32'hA500_0000 | 32'(m << 8) | 32'(w);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < NUM_MEM; m++) begin
      if (tb_init) begin
        for (int w = 0; w < WORDS; w++) bram[m][w] <= pat(m, w);
      end else begin
        for (int b = 0; b < 4; b++)
          if (dbg_we[4*m+b]) bram[m][dbg_a[32*m+2 +: c_AW]][8*b +: 8] <= dbg_wd[8*b +: 8];
      end
      if (dbg_we[4*m +: 4] != 4'h0) we_cnt[m] <= we_cnt[m] + 1;
      rpipe[m][0] <= bram[m][dbg_a[32*m+2 +: c_AW]];
      for (int s = 1; s < RD_LATENCY; s++) rpipe[m][s] <= rpipe[m][s-1];
    end
  end

  for (genvar g = 0; g < NUM_MEM; g++) begin : g_rd
    assign dbg_rd[32*g +: 32] = rpipe[g][RD_LATENCY-1];
  end

  // Reference model: what each memory should hold after the loads so far.
  logic [31:0] exp_mem [NUM_MEM][WORDS];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_addr"},  out_addr,  0);
    chk({tag, "_out_mem"},   out_mem,   0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_dbg_a"},     dbg_a,     0);
    chk({tag, "_dbg_wd"},    dbg_wd,    0);
    chk({tag, "_dbg_we"},    dbg_we,    0);
    chk({tag, "_core_rst"},  core_rst,  1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  // Full load/hold/run/dump sequence. lastN < 0 means no in_last for memory N;
  // halt_at < 0 means no halt; abort_at >= 0 resets the DUT after that many
  // dump words have been accepted.
  task automatic run_seq(input int id, input int last0, input int last1,
                         input int halt_at, input int exp_run, input int exp_w0,
                         input int exp_w1, input bit rdy_hi, input int abort_at);
    int lastv[NUM_MEM];
    int unsigned base[NUM_MEM];
    int n, hold, run, idx, cyc, prev_seen, em, ew;
    bit seen;
    logic [31:0] d, h_data, h_addr;
    logic [c_MW-1:0] h_mem;
    string p;
    p = $sformatf("v%0d", id);
    lastv[0] = last0;
    lastv[1] = last1;
    for (int m = 0; m < NUM_MEM; m++) base[m] = we_cnt[m];

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({p, "_in_ready_start"}, in_ready, 1);
    chk({p, "_done_drop"}, done, 0);
    chk({p, "_busy_load"}, busy, 1);

    for (int m = 0; m < NUM_MEM; m++) begin
      n = (lastv[m] < 0) ? WORDS : lastv[m] + 1;
      for (int w = 0; w < n; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
          @(posedge clk); #1;
          chk({p, "_we_gap"}, dbg_we, 0);
        end
        d        = $urandom;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = (w == lastv[m]);
        start    = (m == 0 && w == 1);
        @(posedge clk); #1;
        exp_mem[m][w] = d;
        chk($sformatf("%s_we_m%0d_w%0d", p, m, w), dbg_we, 64'(4'hF) << (4*m));
        chk($sformatf("%s_a_m%0d_w%0d", p, m, w), dbg_a, 64'(4*w) << (32*m));
        chk($sformatf("%s_wd_m%0d_w%0d", p, m, w), dbg_wd, d);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;

    hold = 0;
    while (core_rst === 1'b1 && hold < 100) begin
      halt = 1'b1;
      hold++;
      @(posedge clk); #1;
    end
    run = 0;
    while (core_rst === 1'b0 && run < 100) begin
      halt  = (run == halt_at);
      start = (run == 1);
      run++;
      @(posedge clk); #1;
    end
    halt = 1'b0; start = 1'b0;
    chk({p, "_hold_len"}, hold, RST_CYCLES);
    chk({p, "_run_len"}, run, exp_run);
    chk({p, "_core_rst_dump"}, core_rst, 1);

    idx = 0; cyc = 0; prev_seen = -1; seen = 1'b0;
    h_data = '0; h_addr = '0; h_mem = '0;
    while (idx < TOTAL && cyc < 400) begin
      if (abort_at >= 0 && idx == abort_at) break;
      em = idx / WORDS;
      ew = idx % WORDS;
      if (out_valid) begin
        chk($sformatf("%s_last_i%0d", p, idx), out_last, (idx == TOTAL - 1));
        if (!seen) begin
          chk($sformatf("%s_data_i%0d", p, idx), out_data, exp_mem[em][ew]);
          chk($sformatf("%s_addr_i%0d", p, idx), out_addr, 4 * ew);
          chk($sformatf("%s_mem_i%0d", p, idx), out_mem, em);
          if (rdy_hi && prev_seen >= 0)
            chk($sformatf("%s_rate_i%0d", p, idx), cyc - prev_seen, RD_LATENCY + 2);
          prev_seen = cyc;
          seen = 1'b1;
          h_data = out_data; h_addr = out_addr; h_mem = out_mem;
        end else begin
          chk($sformatf("%s_hold_i%0d", p, idx), {out_data, out_addr},
              {h_data, h_addr});
          chk($sformatf("%s_hold_mem_i%0d", p, idx), out_mem, h_mem);
        end
      end else begin
        chk($sformatf("%s_last_idle", p), out_last, 0);
      end
      out_ready = rdy_hi ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        idx++;
        seen = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;

    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset({p, "_abort_dump"});
      rst = 1'b0;
      return;
    end

    chk({p, "_dump_count"}, idx, TOTAL);
    chk({p, "_done"}, done, 1);
    chk({p, "_busy_done"}, busy, 0);
    chk({p, "_valid_done"}, out_valid, 0);
    chk({p, "_core_rst_done"}, core_rst, 1);
    chk({p, "_writes_m0"}, we_cnt[0] - base[0], exp_w0);
    chk({p, "_writes_m1"}, we_cnt[1] - base[1], exp_w1);
  endtask

  typedef struct {
    int last0;
    int last1;
    int halt_at;
    int exp_run;
    int exp_w0;
    int exp_w1;
    bit rdy_hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] d;
    vecs[0] = '{last0: -1, last1: -1, halt_at: -1, exp_run: 20, exp_w0: 8, exp_w1: 8, rdy_hi: 1'b1};
    vecs[1] = '{last0:  2, last1: -1, halt_at:  3, exp_run:  4, exp_w0: 3, exp_w1: 8, rdy_hi: 1'b0};
    vecs[2] = '{last0: -1, last1:  0, halt_at:  0, exp_run:  1, exp_w0: 8, exp_w1: 1, rdy_hi: 1'b0};
    vecs[3] = '{last0:  7, last1:  5, halt_at: 19, exp_run: 20, exp_w0: 8, exp_w1: 6, rdy_hi: 1'b0};
    vecs[4] = '{last0:  0, last1:  3, halt_at: -1, exp_run: 20, exp_w0: 1, exp_w1: 4, rdy_hi: 1'b0};

    for (int m = 0; m < NUM_MEM; m++)
      for (int w = 0; w < WORDS; w++) exp_mem[m][w] = pat(m, w);

    rst = 1'b1; tb_init = 1'b1;
    start = 1'b0; halt = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tb_init = 1'b0;
    check_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_seq(i, vecs[i].last0, vecs[i].last1, vecs[i].halt_at, vecs[i].exp_run,
              vecs[i].exp_w0, vecs[i].exp_w1, vecs[i].rdy_hi, -1);

    // Reset during LOAD: words 0..4 land, word 5 collides with reset and is lost.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 6; w++) begin
      d = $urandom;
      in_valid = 1'b1; in_data = d; in_last = 1'b0;
      if (w == 5) rst = 1'b1;
      @(posedge clk); #1;
      if (w < 5) exp_mem[0][w] = d;
    end
    in_valid = 1'b0;
    check_reset("abort_load");
    rst = 1'b0;
    @(posedge clk); #1;

    // One word per memory, so the dump exposes the partial load above.
    run_seq(5, 0, 0, -1, 20, 1, 1, 1'b0, -1);
    run_seq(6, -1, -1, -1, 20, 8, 8, 1'b0, 3);
    @(posedge clk); #1;
    run_seq(7, -1, 2, 5, 6, 8, 3, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
